// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-port read arbiter for a mapped SPI flash reader; optional FLASH_ARB_LASTWORD_CACHE_EN last-word cache
module spi_flash_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_rstrb,
  input  logic [19:0] a_word_address,
  output logic [31:0] a_rdata,
  output logic        a_rbusy,
  input  logic        b_rstrb,
  input  logic [19:0] b_word_address,
  output logic [31:0] b_rdata,
  output logic        b_rbusy,
  output logic        flash_rstrb,
  output logic [19:0] flash_word_address,
  input  logic [31:0] flash_rdata,
  input  logic        flash_rbusy,
  input  logic        inval
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      state;
  state_t      state_nx;

  logic        a_pend;
  logic        b_pend;
  logic [19:0] a_addr;
  logic [19:0] b_addr;
  logic        gnt_b;
  logic        last_b;
  logic [3:0]  wait_cnt;

  logic        a_acc;
  logic        b_acc;
  logic        a_hit;
  logic        b_hit;
  logic        a_hit_busy;
  logic        b_hit_busy;
  logic [31:0] a_hit_data;
  logic [31:0] b_hit_data;
  logic        grant_b;
  logic        done;

  // A port is free to take a strobe only when nothing is outstanding on it
  assign a_rbusy = a_pend | a_hit_busy;
  assign b_rbusy = b_pend | b_hit_busy;
  assign a_acc   = a_rstrb & ~a_rbusy;
  assign b_acc   = b_rstrb & ~b_rbusy;

  // B wins when it is alone, or on a tie when A was served last
  assign grant_b = b_pend & (~a_pend | ~last_b);
  assign done    = (state == WAIT_DONE) & ~flash_rbusy;

`ifdef FLASH_ARB_LASTWORD_CACHE_EN
  logic        a_cvalid;
  logic        b_cvalid;
  logic [19:0] a_ctag;
  logic [19:0] b_ctag;
  logic [31:0] a_cdata;
  logic [31:0] b_cdata;

  assign a_hit      = a_acc & a_cvalid & (a_ctag == a_word_address);
  assign b_hit      = b_acc & b_cvalid & (b_ctag == b_word_address);
  assign a_hit_data = a_cdata;
  assign b_hit_data = b_cdata;

  // Last-word entries: fill on flash completion, inval wins over a fill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_cvalid <= 1'b0;
      b_cvalid <= 1'b0;
      a_ctag   <= '0;
      b_ctag   <= '0;
      a_cdata  <= '0;
      b_cdata  <= '0;
    end else begin
      if (done && !gnt_b) begin
        a_ctag  <= flash_word_address;
        a_cdata <= flash_rdata;
      end
      if (done && gnt_b) begin
        b_ctag  <= flash_word_address;
        b_cdata <= flash_rdata;
      end
      if (inval) begin
        a_cvalid <= 1'b0;
        b_cvalid <= 1'b0;
      end else begin
        if (done && !gnt_b) a_cvalid <= 1'b1;
        if (done && gnt_b)  b_cvalid <= 1'b1;
      end
    end
  end

  // A hit keeps rbusy up for exactly the cycle after the strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_hit_busy <= 1'b0;
      b_hit_busy <= 1'b0;
    end else begin
      a_hit_busy <= a_hit;
      b_hit_busy <= b_hit;
    end
  end
`else
  logic unused_inval;

  assign unused_inval = inval;
  assign a_hit        = 1'b0;
  assign b_hit        = 1'b0;
  assign a_hit_busy   = 1'b0;
  assign b_hit_busy   = 1'b0;
  assign a_hit_data   = '0;
  assign b_hit_data   = '0;
`endif

  // Pending slots: set by an accepted miss, cleared when its flash read completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      a_addr <= '0;
      b_addr <= '0;
    end else begin
      if (a_acc) begin
        a_addr <= a_word_address;
        if (!a_hit) a_pend <= 1'b1;
      end else if (done && !gnt_b) begin
        a_pend <= 1'b0;
      end
      if (b_acc) begin
        b_addr <= b_word_address;
        if (!b_hit) b_pend <= 1'b1;
      end else if (done && gnt_b) begin
        b_pend <= 1'b0;
      end
    end
  end

  // Read data: loaded from the flash on completion or from the cache on a hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (done && !gnt_b) a_rdata <= flash_rdata;
      else if (a_hit)     a_rdata <= a_hit_data;
      if (done && gnt_b)  b_rdata <= flash_rdata;
      else if (b_hit)     b_rdata <= b_hit_data;
    end
  end

  // Grant and flash address are captured once in IDLE and held through the read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_b              <= 1'b0;
      last_b             <= 1'b1;
      flash_word_address <= '0;
    end else begin
      if (state == IDLE && (a_pend || b_pend)) begin
        gnt_b              <= grant_b;
        flash_word_address <= grant_b ? b_addr : a_addr;
      end
      if (done) last_b <= gnt_b;
    end
  end

  // Counts cycles spent waiting for the flash reader to acknowledge a strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == WAIT_BUSY) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and the one-cycle flash strobe
  always_comb begin
    state_nx    = state;
    flash_rstrb = 1'b0;
    case (state)
      IDLE: begin
        if (a_pend || b_pend) state_nx = ISSUE;
      end
      ISSUE: begin
        flash_rstrb = 1'b1;
        state_nx    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (flash_rbusy)             state_nx = WAIT_DONE;
        else if (wait_cnt == 4'd15)  state_nx = ISSUE;
      end
      WAIT_DONE: begin
        if (!flash_rbusy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_rstrb;
  logic [19:0] a_word_address;
  logic [31:0] a_rdata;
  logic        a_rbusy;
  logic        b_rstrb;
  logic [19:0] b_word_address;
  logic [31:0] b_rdata;
  logic        b_rbusy;
  logic        flash_rstrb;
  logic [19:0] flash_word_address;
  logic [31:0] flash_rdata;
  logic        flash_rbusy;
  logic        inval;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mute_n   = 0;
  logic [19:0] flash_log[$];
  logic [19:0] req;

  spi_flash_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .a_rstrb            (a_rstrb),
    .a_word_address     (a_word_address),
    .a_rdata            (a_rdata),
    .a_rbusy            (a_rbusy),
    .b_rstrb            (b_rstrb),
    .b_word_address     (b_word_address),
    .b_rdata            (b_rdata),
    .b_rbusy            (b_rbusy),
    .flash_rstrb        (flash_rstrb),
    .flash_word_address (flash_word_address),
    .flash_rdata        (flash_rdata),
    .flash_rbusy        (flash_rbusy),
    .inval              (inval)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fw(input logic [19:0] a);
    return (a == 20'h00010) ? 32'h11223344 : {12'hC0D, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Log every flash strobe with the address presented alongside it
  always @(negedge clk) if (flash_rstrb) flash_log.push_back(flash_word_address);

  // Flash reader model: acks a strobe one cycle later, busy for three cycles
  initial begin
    flash_rbusy = 1'b0;
    flash_rdata = '0;
    forever begin
      @(negedge clk);
      if (flash_rstrb) begin
        if (mute_n > 0) begin
          mute_n--;
        end else begin
          req = flash_word_address;
          @(negedge clk);
          flash_rbusy = 1'b1;
          repeat (3) @(negedge clk);
          flash_rdata = fw(req);
          flash_rbusy = 1'b0;
        end
      end
    end
  end

  task automatic strobe_a(input logic [19:0] a);
    a_rstrb = 1'b1; a_word_address = a;
    @(negedge clk);
    a_rstrb = 1'b0;
  endtask

  task automatic strobe_b(input logic [19:0] a);
    b_rstrb = 1'b1; b_word_address = a;
    @(negedge clk);
    b_rstrb = 1'b0;
  endtask

  task automatic strobe_ab(input logic [19:0] aa, input logic [19:0] ba);
    a_rstrb = 1'b1; a_word_address = aa;
    b_rstrb = 1'b1; b_word_address = ba;
    @(negedge clk);
    a_rstrb = 1'b0; b_rstrb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((a_rbusy || b_rbusy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n >= 300), 32'd0);
  endtask

  task automatic check_log2(input string tag, input logic [19:0] first, input logic [19:0] second);
    check({tag, "_count"}, flash_log.size(), 2);
    if (flash_log.size() == 2) begin
      check({tag, "_first"}, 32'(flash_log[0]), 32'(first));
      check({tag, "_second"}, 32'(flash_log[1]), 32'(second));
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; inval = 1'b0;
    a_rstrb = 1'b0; b_rstrb = 1'b0; a_word_address = '0; b_word_address = '0;
    repeat (3) @(negedge clk);
    check("rst_a_rbusy", a_rbusy, 0);
    check("rst_b_rbusy", b_rbusy, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_flash_rstrb", flash_rstrb, 0);
    check("rst_flash_addr", 32'(flash_word_address), 0);
    reset = 1'b1;
    @(negedge clk);

    // Simultaneous pair from reset: A wins the first tie
    flash_log.delete();
    strobe_ab(20'h00001, 20'h00002);
    wait_idle("pair1_wait");
    check_log2("pair1", 20'h00001, 20'h00002);
    check("pair1_a_rdata", a_rdata, 32'hC0D00001);
    check("pair1_b_rdata", b_rdata, 32'hC0D00002);

    // Single A read
    flash_log.delete();
    strobe_a(20'h00010);
    check("single_a_busy", a_rbusy, 1);
    wait_idle("single_wait");
    check("single_count", flash_log.size(), 1);
    if (flash_log.size() == 1) check("single_addr", 32'(flash_log[0]), 32'h10);
    check("single_a_rdata", a_rdata, 32'h11223344);
    check("single_a_rbusy", a_rbusy, 0);
    repeat (4) @(negedge clk);
    check("single_a_stable", a_rdata, 32'h11223344);

    // A served last: B wins the tie
    flash_log.delete();
    strobe_ab(20'h00003, 20'h00004);
    wait_idle("pair2_wait");
    check_log2("pair2", 20'h00004, 20'h00003);

    // Strobe on busy B is ignored
    flash_log.delete();
    strobe_b(20'h00020);
    check("ign_b_busy", b_rbusy, 1);
    strobe_b(20'h00030);
    wait_idle("ign_wait");
    check("ign_count", flash_log.size(), 1);
    if (flash_log.size() == 1) check("ign_addr", 32'(flash_log[0]), 32'h20);
    check("ign_b_rdata", b_rdata, 32'hC0D00020);

    // B served last: A wins the tie
    flash_log.delete();
    strobe_ab(20'h00005, 20'h00006);
    wait_idle("pair3_wait");
    check_log2("pair3", 20'h00005, 20'h00006);

    // New strobe accepted in the same cycle rbusy falls
    flash_log.delete();
    strobe_a(20'h00040);
    wait_idle("b2b_wait1");
    strobe_a(20'h00041);
    check("b2b_busy", a_rbusy, 1);
    wait_idle("b2b_wait2");
    check_log2("b2b", 20'h00040, 20'h00041);
    check("b2b_a_rdata", a_rdata, 32'hC0D00041);

    // Unanswered strobe is re-issued after the timeout
    flash_log.delete();
    mute_n = 1;
    strobe_a(20'h00050);
    wait_idle("retry_wait");
    check_log2("retry", 20'h00050, 20'h00050);
    check("retry_a_rdata", a_rdata, 32'hC0D00050);

    // Reset during WAIT_DONE abandons the transfer
    flash_log.delete();
    strobe_b(20'h00060);
    n = 0;
    while (!flash_rbusy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrst_ack_timeout", 32'(n >= 50), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_b_rbusy", b_rbusy, 0);
    check("midrst_b_rdata", b_rdata, 0);
    check("midrst_a_rdata", a_rdata, 0);
    check("midrst_flash_addr", 32'(flash_word_address), 0);
    check("midrst_flash_rstrb", flash_rstrb, 0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (flash_rbusy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("midrst_after_b_rdata", b_rdata, 0);
    check("midrst_after_b_rbusy", b_rbusy, 0);
    check("midrst_strobes", flash_log.size(), 1);

`ifdef FLASH_ARB_LASTWORD_CACHE_EN
    // Repeat address hits the cache; inval forces a flash read again
    flash_log.delete();
    strobe_a(20'h00010);
    wait_idle("cache_fill_wait");
    strobe_a(20'h00010);
    check("cache_hit_busy1", a_rbusy, 1);
    @(negedge clk);
    check("cache_hit_busy0", a_rbusy, 0);
    check("cache_hit_rdata", a_rdata, 32'h11223344);
    check("cache_hit_count", flash_log.size(), 1);
    inval = 1'b1;
    @(negedge clk);
    inval = 1'b0;
    strobe_a(20'h00010);
    wait_idle("cache_inval_wait");
    check("cache_inval_count", flash_log.size(), 2);
    check("cache_inval_rdata", a_rdata, 32'h11223344);
`else
    // Without the cache every repeat goes to the flash, inval has no effect
    flash_log.delete();
    strobe_a(20'h00010);
    wait_idle("nocache_wait1");
    inval = 1'b1;
    strobe_a(20'h00010);
    inval = 1'b0;
    wait_idle("nocache_wait2");
    check_log2("nocache", 20'h00010, 20'h00010);
    check("nocache_rdata", a_rdata, 32'h11223344);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (rising edge).
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: a_rstrb  in  1, a_word_address  in  20, a_rdata  out  32, a_rbusy  out  1 (port A, instruction fetch).
REQ-004 SHALL have: b_rstrb  in  1, b_word_address  in  20, b_rdata  out  32, b_rbusy  out  1 (port B, data load).
REQ-005 SHALL have: flash_rstrb  out  1, flash_word_address  out  20, flash_rdata  in  32, flash_rbusy  in  1 (to the mapped SPI flash reader).
REQ-006 SHALL have: inval  in  1  drop all cached words (used only with the macro).

Function
REQ-007 SHALL take a one-cycle rstrb pulse per port, latching the address into that port's pending slot and setting x_rbusy from the next cycle.
REQ-008 SHALL keep x_rbusy high until x_rdata holds the requested word, then drop it; x_rdata SHALL then stay stable until the next accepted request on that port.
REQ-009 SHALL ignore rstrb on a port whose slot is already pending, leaving the latched address unchanged.
REQ-010 SHALL accept a new rstrb in the same cycle the port's x_rbusy falls.
REQ-011 SHALL run the FSM IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
REQ-012 IDLE: with any slot pending, SHALL grant one slot and go to ISSUE.
REQ-013 ISSUE: SHALL drive flash_rstrb high for exactly one cycle, with flash_word_address equal to the granted address, then go to WAIT_BUSY.
REQ-014 WAIT_BUSY: SHALL wait for flash_rbusy=1, then go to WAIT_DONE; after 16 cycles without it, SHALL return to ISSUE and re-strobe.
REQ-015 WAIT_DONE: on flash_rbusy=0, SHALL copy flash_rdata to the granted port's rdata, clear its slot and return to IDLE; a grant issues at most one flash read at a time.
REQ-016 SHALL grant round-robin when both slots are pending: the port not served last wins.
REQ-017 With one slot pending, SHALL grant it immediately.
REQ-018 SHALL hold flash_word_address stable from ISSUE until WAIT_DONE exits.

Reset
REQ-019 When reset=0, SHALL force: FSM IDLE; both slots clear; a_rbusy=b_rbusy=0; a_rdata=b_rdata=0; flash_rstrb=0; flash_word_address=0; last-served=B, so A wins the first tie; cache invalid.
REQ-020 Reset mid-transfer SHALL abandon the transfer, with no rdata update and no further flash_rstrb.

Configuration
REQ-021 With FLASH_ARB_LASTWORD_CACHE_EN defined, SHALL keep one tag(20)/data(32)/valid entry per port, written when that port's flash read completes.
REQ-022 With the macro defined, a strobe whose address matches a valid tag SHALL hold x_rbusy high for exactly one cycle, return the cached data and skip the flash.
REQ-023 With the macro defined, inval=1 SHALL clear both valid bits that cycle; inval has priority over a completing fill.
REQ-024 Without the macro, SHALL send every request to the flash, ignore inval and contain no cache storage.

Verification
REQ-025 a_rstrb with address 0x00010, flash returns 0x11223344 -> flash_word_address=0x00010, one flash_rstrb pulse, a_rdata=0x11223344, a_rbusy low.
REQ-026 a_rstrb and b_rstrb in the same cycle (0x00001/0x00002) -> A served first, then B; exactly two flash_rstrb pulses.
REQ-027 Two more simultaneous pairs -> grant order B,A then A,B (alternation).
REQ-028 b_rstrb again while b_rbusy=1, with a new address -> ignored; b_rdata holds the first address's data.
REQ-029 Reset pulled low during WAIT_DONE -> all outputs zero next cycle; later flash_rbusy fall causes no rdata change.
REQ-030 Macro defined: a_rstrb 0x00010 twice -> second has a 1-cycle a_rbusy and no flash_rstrb; after an inval pulse, a third strobe reaches the flash.
